// File: rtl/sr_count_monitor_if.sv
// Bus between a counter-side driver and the sr_count_monitor checker:
// sample stimulus one way, registered status back the other.
interface sr_count_monitor_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             err_clr;
    logic             locked;
    logic             wrap_pulse;
    logic             seq_err;
    logic             err_flag;
    logic [CNT_W-1:0] wrap_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, count_in, err_clr,
        input  locked, wrap_pulse, seq_err, err_flag, wrap_count, err_count
    );

    modport slave (
        input  en, count_in, err_clr,
        output locked, wrap_pulse, seq_err, err_flag, wrap_count, err_count
    );
endinterface

// File: rtl/sr_count_monitor.sv
// Checks that a free-running counter steps by exactly +1 mod 2^WIDTH.
// It locks after SYNC_LEN good steps, then reports wraps and sequence errors.
module sr_count_monitor #(
    parameter int WIDTH    = 3,
    parameter int SYNC_LEN = 4,
    parameter int CNT_W    = 8
) (
    input logic                clk,
    input logic                reset,
    sr_count_monitor_if.slave  bus
);
    localparam int RUN_W = $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [WIDTH-1:0]  prev_r, prev_nxt_s;
    logic [RUN_W-1:0]  run_r, run_nxt_s, run_inc_s;
    logic              locked_r;
    logic              wrap_pulse_r, wrap_pulse_nxt_s;
    logic              seq_err_r, seq_err_nxt_s;
    logic              err_flag_r, err_flag_nxt_s;
    logic [CNT_W-1:0]  wrap_count_r, wrap_count_nxt_s;
    logic [CNT_W-1:0]  err_count_r, err_count_nxt_s, err_base_s;
    logic              correct_s;
    logic              wrap_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state and next-output decode for the INIT/SYNC/LOCK tracker.
    always_comb begin
        state_nxt_s      = state_r;
        prev_nxt_s       = prev_r;
        run_nxt_s        = run_r;
        wrap_pulse_nxt_s = 1'b0;
        seq_err_nxt_s    = 1'b0;
        wrap_count_nxt_s = wrap_count_r;
        // X/Z on count_in leaves the equality unknown, which falls to "incorrect".
        correct_s  = (bus.count_in == (prev_r + {{(WIDTH-1){1'b0}}, 1'b1}));
        wrap_s     = (prev_r == {WIDTH{1'b1}}) && (bus.count_in == {WIDTH{1'b0}});
        run_inc_s  = run_r + {{(RUN_W-1){1'b0}}, 1'b1};
        err_base_s = bus.err_clr ? {CNT_W{1'b0}} : err_count_r;
        err_count_nxt_s = err_base_s;
        err_flag_nxt_s  = bus.err_clr ? 1'b0 : err_flag_r;

        if (bus.en) begin
            prev_nxt_s = bus.count_in;
            case (state_r)
                ST_INIT: begin
                    run_nxt_s   = {RUN_W{1'b0}};
                    state_nxt_s = ST_SYNC;
                end
                ST_SYNC: begin
                    if (correct_s) begin
                        if (run_inc_s == RUN_W'(SYNC_LEN)) begin
                            run_nxt_s   = {RUN_W{1'b0}};
                            state_nxt_s = ST_LOCK;
                        end else begin
                            run_nxt_s = run_inc_s;
                        end
                    end else begin
                        run_nxt_s = {RUN_W{1'b0}};
                    end
                end
                ST_LOCK: begin
                    if (correct_s) begin
                        if (wrap_s) begin
                            wrap_pulse_nxt_s = 1'b1;
                            wrap_count_nxt_s = sat_inc(wrap_count_r);
                        end else begin
                            wrap_pulse_nxt_s = 1'b0;
                        end
                    end else begin
                        // A detected error takes precedence over a same-edge clear.
                        seq_err_nxt_s   = 1'b1;
                        err_flag_nxt_s  = 1'b1;
                        err_count_nxt_s = sat_inc(err_base_s);
                        run_nxt_s       = {RUN_W{1'b0}};
                        state_nxt_s     = ST_SYNC;
                    end
                end
                default: begin
                    run_nxt_s   = {RUN_W{1'b0}};
                    state_nxt_s = ST_INIT;
                end
            endcase
        end else begin
            prev_nxt_s = prev_r;
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_INIT;
            prev_r       <= {WIDTH{1'b0}};
            run_r        <= {RUN_W{1'b0}};
            locked_r     <= 1'b0;
            wrap_pulse_r <= 1'b0;
            seq_err_r    <= 1'b0;
            err_flag_r   <= 1'b0;
            wrap_count_r <= {CNT_W{1'b0}};
            err_count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            prev_r       <= prev_nxt_s;
            run_r        <= run_nxt_s;
            locked_r     <= (state_nxt_s == ST_LOCK);
            wrap_pulse_r <= wrap_pulse_nxt_s;
            seq_err_r    <= seq_err_nxt_s;
            err_flag_r   <= err_flag_nxt_s;
            wrap_count_r <= wrap_count_nxt_s;
            err_count_r  <= err_count_nxt_s;
        end
    end

    assign bus.locked     = locked_r;
    assign bus.wrap_pulse = wrap_pulse_r;
    assign bus.seq_err    = seq_err_r;
    assign bus.err_flag   = err_flag_r;
    assign bus.wrap_count = wrap_count_r;
    assign bus.err_count  = err_count_r;
endmodule

// File: tb/tb_sr_count_monitor.sv
// Directed bench for sr_count_monitor; a second instance with CNT_W=2 covers saturation.
module tb_sr_count_monitor;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    sr_count_monitor_if #(.WIDTH(3), .CNT_W(8)) bus1 ();
    sr_count_monitor_if #(.WIDTH(3), .CNT_W(2)) bus2 ();

    sr_count_monitor #(.WIDTH(3), .SYNC_LEN(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    sr_count_monitor #(.WIDTH(3), .SYNC_LEN(4), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample to both instances and wait until just after the edge.
    task automatic step(input logic en, input logic [2:0] val, input logic clr);
        @(negedge clk);
        bus1.en = en; bus1.count_in = val; bus1.err_clr = clr;
        bus2.en = en; bus2.count_in = val; bus2.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},  32'(bus1.locked),     32'd0);
        check({tag, "_wpulse"},  32'(bus1.wrap_pulse), 32'd0);
        check({tag, "_seqerr"},  32'(bus1.seq_err),    32'd0);
        check({tag, "_eflag"},   32'(bus1.err_flag),   32'd0);
        check({tag, "_wcount"},  32'(bus1.wrap_count), 32'd0);
        check({tag, "_ecount"},  32'(bus1.err_count),  32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus1.en = 1'b0; bus1.count_in = 3'd0; bus1.err_clr = 1'b0;
        bus2.en = 1'b0; bus2.count_in = 3'd0; bus2.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Test 1: clean count 0..7,0,1..7,0,1
        step(1'b1, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        check("t1_unlocked_at3", 32'(bus1.locked), 32'd0);
        step(1'b1, 3'd4, 1'b0);
        check("t1_locked_at4", 32'(bus1.locked), 32'd1);
        step(1'b1, 3'd5, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        check("t1_no_pulse_at7", 32'(bus1.wrap_pulse), 32'd0);
        step(1'b1, 3'd0, 1'b0);
        check("t1_wrap_pulse1", 32'(bus1.wrap_pulse), 32'd1);
        check("t1_wrap_count1", 32'(bus1.wrap_count), 32'd1);
        step(1'b1, 3'd1, 1'b0);
        check("t1_pulse_one_cycle", 32'(bus1.wrap_pulse), 32'd0);
        for (int v = 2; v <= 7; v++) step(1'b1, 3'(v), 1'b0);
        step(1'b1, 3'd0, 1'b0);
        check("t1_wrap_pulse2", 32'(bus1.wrap_pulse), 32'd1);
        check("t1_wrap_count2", 32'(bus1.wrap_count), 32'd2);
        step(1'b1, 3'd1, 1'b0);

        // Test 2: skip 3->5 in LOCK, then relock through a wrap in SYNC
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        check("t2_no_err_yet", 32'(bus1.seq_err), 32'd0);
        step(1'b1, 3'd5, 1'b0);
        check("t2_seq_err", 32'(bus1.seq_err), 32'd1);
        check("t2_err_count", 32'(bus1.err_count), 32'd1);
        check("t2_err_flag", 32'(bus1.err_flag), 32'd1);
        check("t2_unlocked", 32'(bus1.locked), 32'd0);
        step(1'b1, 3'd6, 1'b0);
        check("t2_seq_err_one_cycle", 32'(bus1.seq_err), 32'd0);
        step(1'b1, 3'd7, 1'b0);
        step(1'b1, 3'd0, 1'b0);
        check("t2_sync_wrap_no_pulse", 32'(bus1.wrap_pulse), 32'd0);
        check("t2_sync_wrap_no_count", 32'(bus1.wrap_count), 32'd2);
        check("t2_still_unlocked", 32'(bus1.locked), 32'd0);
        step(1'b1, 3'd1, 1'b0);
        check("t2_relocked", 32'(bus1.locked), 32'd1);

        // Test 3: en=0 with garbage on count_in, then resume with 2
        step(1'b0, 3'd6, 1'b0);
        check("t3_hold_seq_err_a", 32'(bus1.seq_err), 32'd0);
        step(1'b0, 3'd2, 1'b0);
        check("t3_hold_locked_b", 32'(bus1.locked), 32'd1);
        step(1'b0, 3'd5, 1'b0);
        check("t3_hold_seq_err_c", 32'(bus1.seq_err), 32'd0);
        step(1'b1, 3'd2, 1'b0);
        check("t3_resume_locked", 32'(bus1.locked), 32'd1);
        check("t3_resume_no_err", 32'(bus1.seq_err), 32'd0);
        check("t3_err_count_kept", 32'(bus1.err_count), 32'd1);
        check("t3_wrap_count_kept", 32'(bus1.wrap_count), 32'd2);

        // Test 4: build err_count=3, then error and clear on the same edge
        step(1'b1, 3'd4, 1'b0);
        check("t4_err_count2", 32'(bus1.err_count), 32'd2);
        for (int v = 5; v <= 7; v++) step(1'b1, 3'(v), 1'b0);
        step(1'b1, 3'd0, 1'b0);
        check("t4_relock_a", 32'(bus1.locked), 32'd1);
        step(1'b1, 3'd2, 1'b0);
        check("t4_err_count3", 32'(bus1.err_count), 32'd3);
        for (int v = 3; v <= 6; v++) step(1'b1, 3'(v), 1'b0);
        check("t4_relock_b", 32'(bus1.locked), 32'd1);
        step(1'b1, 3'd0, 1'b1);
        check("t4_clr_err_seq", 32'(bus1.seq_err), 32'd1);
        check("t4_clr_err_count", 32'(bus1.err_count), 32'd1);
        check("t4_clr_err_flag", 32'(bus1.err_flag), 32'd1);
        step(1'b0, 3'd0, 1'b1);
        check("t4_clr_count", 32'(bus1.err_count), 32'd0);
        check("t4_clr_flag", 32'(bus1.err_flag), 32'd0);
        step(1'b0, 3'd0, 1'b0);

        // Test 5: relock, then async reset between edges
        for (int v = 1; v <= 4; v++) step(1'b1, 3'(v), 1'b0);
        check("t5_pre_locked", 32'(bus1.locked), 32'd1);
        check("t5_pre_wcount", 32'(bus1.wrap_count), 32'd2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t5_async");
        @(negedge clk);
        reset = 1'b1;
        for (int v = 0; v <= 3; v++) step(1'b1, 3'(v), 1'b0);
        check("t5_not_yet_locked", 32'(bus1.locked), 32'd0);
        step(1'b1, 3'd4, 1'b0);
        check("t5_locked_after5", 32'(bus1.locked), 32'd1);
        check("t5_locked_dut2", 32'(bus2.locked), 32'd1);

        // Test 6: five wraps; CNT_W=2 instance saturates at 3
        for (int w = 1; w <= 5; w++) begin
            for (int v = 5; v <= 7; v++) step(1'b1, 3'(v), 1'b0);
            step(1'b1, 3'd0, 1'b0);
            check($sformatf("t6_pulse2_w%0d", w), 32'(bus2.wrap_pulse), 32'd1);
            check($sformatf("t6_count2_w%0d", w), 32'(bus2.wrap_count), (w < 3) ? 32'(w) : 32'd3);
            check($sformatf("t6_count1_w%0d", w), 32'(bus1.wrap_count), 32'(w));
            for (int v = 1; v <= 4; v++) step(1'b1, 3'(v), 1'b0);
        end
        check("t6_pulse_clear", 32'(bus2.wrap_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
